// File: rtl/reg_writeback_queue.sv
// ============================================================================
// Module   : reg_writeback_queue
// Purpose  : FIFO of register-file writes drained one per cycle onto the single
//            write port, with in-flight hazard queries for decode.
// Options  : WBQ_BYPASS_EN - an accept into an empty queue goes straight to the
//            output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [ADDR_W-1:0]            InRegister,
  input  logic [DATA_W-1:0]            InData,
  input  logic                         Flush,
  output logic [ADDR_W-1:0]            WriteRegister,
  output logic [DATA_W-1:0]            WriteData,
  output logic                         RegWrite,
  input  logic [ADDR_W-1:0]            QueryRegister1,
  input  logic [ADDR_W-1:0]            QueryRegister2,
  output logic                         Pending1,
  output logic                         Pending2,
  output logic [$clog2(DEPTH):0]       Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;

  logic w_accept, w_keep, w_not_empty, w_bypass, w_push, w_pop;
  logic w_hit1, w_hit2;

  assign InReady     = rst_n && !Flush && (count_q < CW'(DEPTH));
  assign w_accept    = InValid && InReady;
  // Register zero is hardwired, so such requests are consumed without effect.
  assign w_keep      = w_accept && (InRegister != '0);
  assign w_not_empty = (count_q != '0);

`ifdef WBQ_BYPASS_EN
  assign w_bypass = w_keep && !w_not_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_keep && !w_bypass;
  assign w_pop  = w_not_empty && !Flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    rw_d    = 1'b0;
    if (Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      vld_d   = '0;
    end else begin
      if (w_pop) begin
        wreg_d        = reg_mem_q[head_q];
        wdata_d       = data_mem_q[head_q];
        rw_d          = 1'b1;
        head_d        = head_q + PW'(1);
        vld_d[head_q] = 1'b0;
      end
      if (w_bypass) begin
        wreg_d  = InRegister;
        wdata_d = InData;
        rw_d    = 1'b1;
      end
      if (w_push) begin
        tail_d        = tail_q + PW'(1);
        vld_d[tail_q] = 1'b1;
      end
      count_d = count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      reg_mem_q[tail_q]  <= InRegister;
      data_mem_q[tail_q] <= InData;
    end
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (reg_mem_q[i] == QueryRegister1)) w_hit1 = 1'b1;
      if (vld_q[i] && (reg_mem_q[i] == QueryRegister2)) w_hit2 = 1'b1;
    end
  end

  assign Pending1 = (QueryRegister1 != '0) &&
                    (w_hit1 || (rw_q && (wreg_q == QueryRegister1)));
  assign Pending2 = (QueryRegister2 != '0) &&
                    (w_hit2 || (rw_q && (wreg_q == QueryRegister2)));

  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign RegWrite      = rw_q;
  assign Count         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
// ============================================================================
// Module   : tb_reg_writeback_queue
// Purpose  : Scoreboard bench for reg_writeback_queue (DEPTH=4, DATA_W=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback_queue;

`ifdef WBQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  InRegister = '0;
  logic [31:0] InData = '0;
  logic        Flush = 1'b0;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  QueryRegister1 = '0;
  logic [4:0]  QueryRegister2 = '0;
  logic        Pending1;
  logic        Pending2;
  logic [2:0]  Count;

  int  checks = 0;
  int  passed = 0;
  wr_t exp_q[$];

  reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .Flush(Flush),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .QueryRegister1(QueryRegister1), .QueryRegister2(QueryRegister2),
    .Pending1(Pending1), .Pending2(Pending2), .Count(Count)
  );

  always #5 clk = ~clk;

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && RegWrite === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL strobe_unexpected: got r%0d=%h, expected none", WriteRegister, WriteData);
      end else begin
        e = exp_q.pop_front();
        if ({WriteRegister, WriteData} !== {e.r, e.d})
          $display("FAIL strobe_data: got r%0d=%h, expected r%0d=%h",
                   WriteRegister, WriteData, e.r, e.d);
        else passed++;
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
    InValid = v; InRegister = r; InData = d;
    if (v && r != 5'd0) exp_q.push_back('{r: r, d: d});
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({RegWrite, WriteRegister, WriteData, Count, InReady} !== '0)
      $display("FAIL reset_state: got rw=%b wr=%0d wd=%h cnt=%0d rdy=%b, expected all 0",
               RegWrite, WriteRegister, WriteData, Count, InReady);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (InReady !== 1'b1 || Count !== 3'd0)
      $display("FAIL reset_release: got rdy=%b cnt=%0d, expected 1/0", InReady, Count);
    else passed++;
    // Assert reset mid-traffic while a write is staged.
    @(posedge clk); #1;
    QueryRegister1 = 5'd2;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1'b1, 5'd1, 32'hAAAA0001);
      else if (c == 1) drive(1'b1, 5'd2, 32'hAAAA0002);
      else drive(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (RegWrite !== 1'b1 || Count !== ((LAT == 2) ? 3'd1 : 3'd0))
          $display("FAIL reset_pre_traffic: got rw=%b cnt=%0d, expected 1/%0d",
                   RegWrite, Count, (LAT == 2) ? 1 : 0);
        else passed++;
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({RegWrite, WriteRegister, WriteData, Count, InReady, Pending1} !== '0)
      $display("FAIL reset_midtraffic: got rw=%b wr=%0d wd=%h cnt=%0d rdy=%b p1=%b, expected all 0",
               RegWrite, WriteRegister, WriteData, Count, InReady, Pending1);
    else passed++;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (InReady !== 1'b1) $display("FAIL reset_ready_after: got %b, expected 1", InReady);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    QueryRegister1 = 5'd5;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b1, 5'd5, 32'hDEADBEEF);
      else drive(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if (RegWrite !== (c == LAT))
        $display("FAIL single_strobe c%0d: got %b, expected %b", c, RegWrite, (c == LAT));
      else passed++;
      checks++;
      if (Pending1 !== (c >= 1 && c <= LAT))
        $display("FAIL single_pending c%0d: got %b, expected %b", c, Pending1, (c >= 1 && c <= LAT));
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL single_drained: got %0d left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] seen = '0;
    logic [11:0] want;
    want = 12'h03F << LAT;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(1'b1, 5'(c + 1), 32'h100 + 32'(c));
      else drive(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      seen[c] = RegWrite;
      if (c < 6) begin
        checks++;
        if (InReady !== 1'b1) $display("FAIL burst_ready c%0d: got %b, expected 1", c, InReady);
        else passed++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== want) $display("FAIL burst_pattern: got %b, expected %b", seen, want);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL burst_drained: got %0d left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reg_zero;
    logic [7:0] seen = '0;
    logic [7:0] want;
    want = (8'd1 << LAT) | (8'd1 << (LAT + 2));
    QueryRegister2 = 5'd0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) drive(1'b1, 5'd2, 32'h000000A2);
      else if (c == 1) drive(1'b1, 5'd0, 32'h00001234);
      else if (c == 2) drive(1'b1, 5'd3, 32'h000000A3);
      else drive(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      seen[c] = RegWrite;
      checks++;
      if (Pending2 !== 1'b0) $display("FAIL zero_pending c%0d: got %b, expected 0", c, Pending2);
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== want) $display("FAIL zero_pattern: got %b, expected %b", seen, want);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL zero_drained: got %0d left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_same_reg;
    QueryRegister1 = 5'd7;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(1'b1, 5'd7, 32'h1);
      else if (c == 1) drive(1'b1, 5'd7, 32'h2);
      else drive(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      checks++;
      if (Pending1 !== (c >= 1 && c <= LAT + 1))
        $display("FAIL samereg_pending c%0d: got %b, expected %b", c, Pending1, (c >= 1 && c <= LAT + 1));
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL samereg_drained: got %0d left, expected 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_flush;
    QueryRegister1 = 5'd10;
    QueryRegister2 = 5'd11;
    for (int c = 0; c < 6; c++) begin
      Flush = 1'b0;
      if (c == 0) drive(1'b1, 5'd9, 32'h99);
      else if (c == 1) begin
        InValid = 1'b1; InRegister = 5'd10; InData = 32'h1010;
        exp_q.push_back('{r: 5'd10, d: 32'h1010});
        if (LAT == 2) void'(exp_q.pop_back());
      end else if (c == 2) begin
        Flush = 1'b1; InValid = 1'b1; InRegister = 5'd11; InData = 32'h1111;
      end else drive(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (InReady !== 1'b0 || Count !== ((LAT == 2) ? 3'd1 : 3'd0) || RegWrite !== 1'b1)
          $display("FAIL flush_cycle: got rdy=%b cnt=%0d rw=%b, expected 0/%0d/1",
                   InReady, Count, RegWrite, (LAT == 2) ? 1 : 0);
        else passed++;
      end
      if (c == 3) begin
        checks++;
        if ({Count, RegWrite, Pending1, Pending2} !== '0)
          $display("FAIL flush_after: got cnt=%0d rw=%b p1=%b p2=%b, expected all 0",
                   Count, RegWrite, Pending1, Pending2);
        else passed++;
      end
      if (c > 3) begin
        checks++;
        if (RegWrite !== 1'b0) $display("FAIL flush_quiet c%0d: got %b, expected 0", c, RegWrite);
        else passed++;
      end
      @(posedge clk); #1;
    end
    Flush = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL flush_drained: got %0d left, expected 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reg_zero();
    test_same_reg();
    test_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
